// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES encryption datapath: owns the cipher state and step enables.
// Optional abort input is compiled in when AES_CTRL_ABORT_EN is defined.
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [127:0]   data_in,
    input  logic           key_valid,
    input  logic [127:0]   sb_out,
    input  logic [127:0]   sr_out,
    input  logic [127:0]   mc_out,
    input  logic [127:0]   ark_out,
`ifdef AES_CTRL_ABORT_EN
    input  logic           abort,
`endif
    output logic [127:0]   state_q,
    output logic           sb_enable,
    output logic           sr_enable,
    output logic           mc_enable,
    output logic           ark_enable,
    output logic [RW-1:0]  key_index,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARK,
        S_SB,
        S_SR,
        S_MC,
        S_DONE
    } state_t;

    typedef struct packed {
        logic sb;
        logic sr;
        logic mc;
        logic ark;
        logic busy;
        logic done;
    } outs_t;

    localparam logic [RW-1:0] LP_NR = RW'(NR);

    state_t          r_state;
    outs_t           r_outs;
    logic [127:0]    r_state_q;
    logic [RW-1:0]   r_key_index;
    logic            w_abort;

    // Outputs are registered alongside the state they belong to, so they are a pure function of it.
    function automatic outs_t decode(input state_t s);
        outs_t o;
        o.sb   = (s == S_SB);
        o.sr   = (s == S_SR);
        o.mc   = (s == S_MC);
        o.ark  = (s == S_ARK);
        o.busy = (s == S_ARK) || (s == S_SB) || (s == S_SR) || (s == S_MC);
        o.done = (s == S_DONE);
        return o;
    endfunction

`ifdef AES_CTRL_ABORT_EN
    assign w_abort = abort & r_outs.busy;
`else
    assign w_abort = 1'b0;
`endif

    // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_outs      <= '0;
            r_state_q   <= '0;
            r_key_index <= '0;
        end else if (w_abort) begin
            r_state     <= S_IDLE;
            r_outs      <= decode(S_IDLE);
            r_state_q   <= '0;
            r_key_index <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state_q   <= data_in;
                        r_key_index <= '0;
                        r_state     <= S_ARK;
                        r_outs      <= decode(S_ARK);
                    end
                end
                S_ARK: begin
                    if (key_valid) begin
                        r_state_q <= ark_out;
                        if (r_key_index == LP_NR) begin
                            r_state <= S_DONE;
                            r_outs  <= decode(S_DONE);
                        end else begin
                            r_key_index <= r_key_index + 1'b1;
                            r_state     <= S_SB;
                            r_outs      <= decode(S_SB);
                        end
                    end
                end
                S_SB: begin
                    r_state_q <= sb_out;
                    r_state   <= S_SR;
                    r_outs    <= decode(S_SR);
                end
                S_SR: begin
                    r_state_q <= sr_out;
                    // The final round has no MixColumns step.
                    if (r_key_index == LP_NR) begin
                        r_state <= S_ARK;
                        r_outs  <= decode(S_ARK);
                    end else begin
                        r_state <= S_MC;
                        r_outs  <= decode(S_MC);
                    end
                end
                S_MC: begin
                    r_state_q <= mc_out;
                    r_state   <= S_ARK;
                    r_outs    <= decode(S_ARK);
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_outs  <= decode(S_IDLE);
                end
                default: begin
                    r_state <= S_IDLE;
                    r_outs  <= decode(S_IDLE);
                end
            endcase
        end
    end

    assign state_q    = r_state_q;
    assign sb_enable  = r_outs.sb;
    assign sr_enable  = r_outs.sr;
    assign mc_enable  = r_outs.mc;
    assign ark_enable = r_outs.ark;
    assign busy       = r_outs.busy;
    assign done       = r_outs.done;
    assign key_index  = r_key_index;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: reference AES step blocks and key schedule drive the sequencer,
// results are compared against a whole-cipher reference. Define AES_CTRL_ABORT_EN to cover abort.
`timescale 1ns/1ps
module tb_aes_round_ctrl;

    localparam int NR     = 10;
    localparam int RW     = 4;
    localparam int LAT    = 1 + 4*(NR-1) + 3;
    localparam int MAXCYC = 300;
    localparam int ST_ARK = 1;
    localparam int ST_SB  = 2;
    localparam int ST_SR  = 3;
    localparam int ST_MC  = 4;

    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [127:0]  data_in;
    logic          key_valid;
    logic [127:0]  sb_out, sr_out, mc_out, ark_out;
    logic [127:0]  state_q;
    logic          sb_enable, sr_enable, mc_enable, ark_enable;
    logic [RW-1:0] key_index;
    logic          busy, done;
`ifdef AES_CTRL_ABORT_EN
    logic          abort;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] rk_tab   [0:15];
    logic         mc_force;
    logic [31:0]  mc_force_col;
    int           q_steps[$];
    int           q_kidx[$];

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(NR), .RW(RW)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .key_valid(key_valid),
        .sb_out(sb_out), .sr_out(sr_out), .mc_out(mc_out), .ark_out(ark_out),
`ifdef AES_CTRL_ABORT_EN
        .abort(abort),
`endif
        .state_q(state_q), .sb_enable(sb_enable), .sr_enable(sr_enable), .mc_enable(mc_enable),
        .ark_enable(ark_enable), .key_index(key_index), .busy(busy), .done(done)
    );

    // ---------------- reference AES arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254, followed by the affine transform.
    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_tab[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [0:4*(NR+1)-1];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k <= NR; k++) rk_tab[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk_tab[0];
        for (int r = 1; r <= NR; r++) begin
            s = shift_rows(sub_bytes(s));
            if (r != NR) s = mix_columns(s);
            s = s ^ rk_tab[r];
        end
        return s;
    endfunction

    // Step blocks as seen by the sequencer.
    always_comb begin
        sb_out = sub_bytes(state_q);
        sr_out = shift_rows(state_q);
        mc_out = mix_columns(state_q);
        if (mc_force) mc_out[127:96] = mc_force_col;
        ark_out = state_q ^ rk_tab[key_index];
    end

    // ---------------- encryption driver with per-cycle invariants ----------------
    task automatic run_enc(input logic [127:0] pt, input int stall_kidx, input int stall_n,
                           input bit rand_mode, input bit poke_start,
                           output int edges, output int stalls, output logic [127:0] ct);
        int stall_left;
        bit fin;
        bit poked;
        stall_left = stall_n;
        stalls = 0;
        fin = 1'b0;
        poked = 1'b0;
        edges = 0;
        ct = '0;
        q_steps.delete();
        q_kidx.delete();
        @(negedge clk);
        data_in = pt; start = 1'b1; key_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        while (!fin && edges < MAXCYC) begin
            if (done) begin
                fin = 1'b1;
                ct = state_q;
                vectors++;
                if (busy !== 1'b0 || {sb_enable, sr_enable, mc_enable, ark_enable} !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL done_outputs: busy=%b enables=%b, expected busy=0 enables=0000",
                             busy, {sb_enable, sr_enable, mc_enable, ark_enable});
                end
                start = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
                data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            end else begin
                vectors++;
                if (busy !== 1'b1 || $countones({sb_enable, sr_enable, mc_enable, ark_enable}) != 1
                    || key_index > NR) begin
                    miscompares++;
                    $display("FAIL busy_onehot at edge %0d: busy=%b enables=%b key_index=%0d, expected busy=1 one-hot key_index<=%0d",
                             edges, busy, {sb_enable, sr_enable, mc_enable, ark_enable}, key_index, NR);
                end
                key_valid = 1'b1;
                if (ark_enable) begin
                    if (rand_mode) key_valid = ($urandom_range(0, 3) != 0);
                    else if (int'(key_index) == stall_kidx && stall_left > 0) begin
                        key_valid = 1'b0;
                        stall_left--;
                    end
                    if (!key_valid) stalls++;
                    else begin
                        q_steps.push_back(ST_ARK);
                        q_kidx.push_back(int'(key_index));
                    end
                end else begin
                    if (sb_enable) q_steps.push_back(ST_SB);
                    if (sr_enable) q_steps.push_back(ST_SR);
                    if (mc_enable) q_steps.push_back(ST_MC);
                    if (rand_mode) key_valid = 1'($urandom_range(0, 1));
                end
                if (rand_mode) start = 1'($urandom_range(0, 1));
                else if (poke_start && sr_enable && !poked) begin
                    start = 1'b1;
                    poked = 1'b1;
                end else start = 1'b0;
                data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            @(negedge clk);
            if (!fin) edges++;
        end
        start = 1'b0;
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL done_timeout: no done within %0d cycles", MAXCYC);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end else if (done !== 1'b0 || busy !== 1'b0 || state_q !== ct) begin
            miscompares++;
            $display("FAIL idle_after_done: done=%b busy=%b state_q=%h, expected done=0 busy=0 state_q=%h",
                     done, busy, state_q, ct);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        #2;
        vectors++;
        if ({state_q, key_index} !== '0 || {sb_enable, sr_enable, mc_enable, ark_enable, busy, done} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_state: state_q=%h key_index=%0d flags=%b, expected all zero",
                     state_q, key_index, {sb_enable, sr_enable, mc_enable, ark_enable, busy, done});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || state_q !== '0) begin
            miscompares++;
            $display("FAIL idle_no_start: busy=%b state_q=%h, expected busy=0 state_q=0", busy, state_q);
        end
    endtask

    task automatic test_known_vector();
        int edges, stalls;
        logic [127:0] ct;
        set_key(KAT_KEY);
        run_enc(KAT_PT, -1, 0, 1'b0, 1'b0, edges, stalls, ct);
        vectors++;
        if (ct !== KAT_CT) begin
            miscompares++;
            $display("FAIL kat_ciphertext: got %h, expected %h", ct, KAT_CT);
        end
        vectors++;
        if (edges != LAT) begin
            miscompares++;
            $display("FAIL kat_latency: done at edge %0d, expected %0d", edges, LAT);
        end
    endtask

    task automatic test_step_sequence();
        int edges, stalls, mc_count, bad;
        logic [127:0] ct;
        int exp_steps[$];
        set_key(KAT_KEY);
        run_enc(KAT_PT, -1, 0, 1'b0, 1'b0, edges, stalls, ct);
        exp_steps.push_back(ST_ARK);
        for (int r = 1; r <= NR; r++) begin
            exp_steps.push_back(ST_SB);
            exp_steps.push_back(ST_SR);
            if (r < NR) exp_steps.push_back(ST_MC);
            exp_steps.push_back(ST_ARK);
        end
        bad = -1;
        for (int i = 0; i < exp_steps.size(); i++)
            if (bad < 0 && (i >= q_steps.size() || q_steps[i] != exp_steps[i])) bad = i;
        vectors++;
        if (bad >= 0 || q_steps.size() != exp_steps.size()) begin
            miscompares++;
            $display("FAIL step_order: first difference at step %0d, got %0d steps, expected %0d",
                     bad, q_steps.size(), exp_steps.size());
        end
        mc_count = 0;
        foreach (q_steps[i]) if (q_steps[i] == ST_MC) mc_count++;
        vectors++;
        if (mc_count != NR - 1) begin
            miscompares++;
            $display("FAIL mc_count: got %0d, expected %0d", mc_count, NR - 1);
        end
        bad = (q_kidx.size() != NR + 1) ? 99 : -1;
        foreach (q_kidx[i]) if (bad < 0 && q_kidx[i] != i) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL ark_key_index: wrong key index at ARK step %0d (%0d ARK steps), expected 0..%0d",
                     bad, q_kidx.size(), NR);
        end
    endtask

    task automatic test_mc_capture();
        bit found;
        found = 1'b0;
        set_key(KAT_KEY);
        @(negedge clk);
        data_in = KAT_PT; start = 1'b1; key_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < MAXCYC && !found; i++) begin
            if (mc_enable && key_index == 1) found = 1'b1;
            else @(negedge clk);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL mc_round1_reached: mc_enable with key_index=1 never seen");
        end else begin
            mc_force = 1'b1;
            mc_force_col = 32'h046681e5;
            @(negedge clk);
            mc_force = 1'b0;
            vectors++;
            if (state_q[127:96] !== 32'h046681e5) begin
                miscompares++;
                $display("FAIL mc_capture: state_q[127:96]=%h, expected 046681e5", state_q[127:96]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stall_and_start();
        int edges, stalls;
        logic [127:0] ct;
        set_key(KAT_KEY);
        run_enc(KAT_PT, 4, 3, 1'b0, 1'b1, edges, stalls, ct);
        vectors++;
        if (edges != LAT + 3) begin
            miscompares++;
            $display("FAIL stall_latency: done at edge %0d, expected %0d", edges, LAT + 3);
        end
        vectors++;
        if (ct !== KAT_CT) begin
            miscompares++;
            $display("FAIL stall_ciphertext: got %h, expected %h", ct, KAT_CT);
        end
    endtask

    task automatic test_reset_mid_run();
        int edges, stalls;
        bit seen;
        logic [127:0] ct, pt;
        pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        set_key({$urandom(), $urandom(), $urandom(), $urandom()});
        @(negedge clk);
        data_in = pt; start = 1'b1; key_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrun_busy: busy=%b before reset, expected 1", busy);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({state_q, key_index} !== '0 || {sb_enable, sr_enable, mc_enable, ark_enable, busy, done} !== 6'b0) begin
            miscompares++;
            $display("FAIL midrun_reset: state_q=%h key_index=%0d flags=%b, expected all zero",
                     state_q, key_index, {sb_enable, sr_enable, mc_enable, ark_enable, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL midrun_no_done: activity after reset, expected none");
        end
        run_enc(pt, -1, 0, 1'b0, 1'b0, edges, stalls, ct);
        vectors++;
        if (edges != LAT || ct !== aes_ref(pt)) begin
            miscompares++;
            $display("FAIL midrun_restart: edge %0d ct %h, expected edge %0d ct %h", edges, ct, LAT, aes_ref(pt));
        end
    endtask

    task automatic test_random();
        int edges, stalls;
        logic [127:0] ct, pt, exp;
        for (int n = 0; n < 24; n++) begin
            set_key({$urandom(), $urandom(), $urandom(), $urandom()});
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            exp = aes_ref(pt);
            run_enc(pt, -1, 0, 1'b1, 1'b0, edges, stalls, ct);
            vectors++;
            if (ct !== exp) begin
                miscompares++;
                $display("FAIL rand_ciphertext[%0d]: got %h, expected %h", n, ct, exp);
            end
            vectors++;
            if (edges != LAT + stalls) begin
                miscompares++;
                $display("FAIL rand_latency[%0d]: done at edge %0d, expected %0d", n, edges, LAT + stalls);
            end
        end
    endtask

`ifdef AES_CTRL_ABORT_EN
    task automatic test_abort();
        int edges, stalls;
        bit found, seen;
        logic [127:0] ct, pt;
        found = 1'b0;
        pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        set_key({$urandom(), $urandom(), $urandom(), $urandom()});
        @(negedge clk);
        data_in = pt; start = 1'b1; key_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < MAXCYC && !found; i++) begin
            if (mc_enable && key_index == 6) found = 1'b1;
            else @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (!found || busy !== 1'b0 || state_q !== '0 || key_index !== '0
            || {sb_enable, sr_enable, mc_enable, ark_enable, done} !== 5'b0) begin
            miscompares++;
            $display("FAIL abort_idle: found=%b busy=%b state_q=%h key_index=%0d, expected idle and zero",
                     found, busy, state_q, key_index);
        end
        seen = 1'b0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (done !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL abort_no_done: done pulsed after abort, expected none");
        end
        run_enc(pt, -1, 0, 1'b0, 1'b0, edges, stalls, ct);
        vectors++;
        if (ct !== aes_ref(pt)) begin
            miscompares++;
            $display("FAIL abort_restart: got %h, expected %h", ct, aes_ref(pt));
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        data_in = '0;
        key_valid = 1'b0;
        mc_force = 1'b0;
        mc_force_col = '0;
`ifdef AES_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
        for (int i = 0; i < 16; i++) rk_tab[i] = '0;
        test_reset();
        test_known_vector();
        test_step_sequence();
        test_mc_capture();
        test_stall_and_start();
        test_reset_mid_run();
        test_random();
`ifdef AES_CTRL_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequencer for the iterative AES-128 encryption datapath.
- Holds the 128-bit cipher state register and drives the per-step enables of the SubBytes, ShiftRows, MixColumns and AddRoundKey blocks (mc_enable included).
- Tracks the round count, requests round keys from key expansion, and presents a start/busy/done handshake to the top-level controller.
- Contains no transform logic; each step's result returns on a dedicated input port.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256).
- RW, 4, round counter width; must satisfy 2^RW > NR.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  request to encrypt data_in; sampled only in IDLE
- data_in  in  128  plaintext, captured on accepted start
- key_valid  in  1  round key for key_index is valid on the ARK datapath
- sb_out  in  128  SubBytes result of state_q
- sr_out  in  128  ShiftRows result of state_q
- mc_out  in  128  MixColumns result of state_q
- ark_out  in  128  state_q XOR round key
- state_q  out  128  cipher state register; feeds all step blocks
- sb_enable  out  1  SubBytes step active
- sr_enable  out  1  ShiftRows step active
- mc_enable  out  1  MixColumns step active
- ark_enable  out  1  AddRoundKey step active
- key_index  out  RW  round key number requested (0..NR)
- busy  out  1  high from accepted start until DONE
- done  out  1  one-cycle pulse; state_q holds ciphertext

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - state_q=0, key_index=0.
  - All enables, busy and done are 0.
  - An in-flight encryption is discarded with no done pulse.
- States: IDLE, ARK, SB, SR, MC, DONE.
- Enables are one-hot, decoded from the current state (Moore). All are 0 in IDLE and DONE.
- IDLE:
  - start=1: state_q<=data_in, key_index<=0, next state ARK.
  - start=0: remain in IDLE.
- ARK:
  - key_valid=0: stall, state_q and key_index unchanged.
  - key_valid=1: state_q<=ark_out.
    - key_index==NR: next state DONE.
    - Otherwise: key_index<=key_index+1, next state SB.
- SB: state_q<=sb_out, next state SR.
- SR: state_q<=sr_out.
  - key_index==NR (final round): next state ARK; MixColumns is skipped.
  - Otherwise: next state MC.
- MC: state_q<=mc_out, next state ARK.
- DONE: done=1 for exactly one cycle, busy=0, state_q held, next state IDLE.
- busy is 1 in ARK, SB, SR and MC.
- Latency with key_valid held high: done is high in the cycle after the 40th rising edge counted from the start-accept edge (1 + 4*(NR-1) + 3 edges for NR=10). Each key_valid-low cycle in ARK adds one cycle.
- Ignored starts:
  - start while busy is ignored; data_in is not sampled.
  - start during DONE is ignored; a new start is accepted only in IDLE, which is the cycle after done.
- state_q is stable between step updates. Step outputs are combinational, so each step completes in one cycle.
- key_index never exceeds NR and never wraps.

Optional Feature:
- Macro AES_CTRL_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort=1 in any busy state: next state IDLE, busy=0, no done pulse, state_q<=0, key_index<=0.
  - In IDLE and DONE, abort is ignored.
  - abort has priority over key_valid stalls.
- Undefined: port absent; behaviour as above.

Test Plan:
- Reset mid-run: start, then assert rst at cycle 17 -> outputs all 0 immediately; no done pulse; a subsequent start runs a full 40-cycle encryption.
- Full vector: bench connects reference SB/SR/MC/ARK and key expansion models, key_valid=1. data_in=00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> done at edge 40, state_q=69c4e0d86a7b0430d8cdb78070b4c55a, busy high for edges 1-39.
- Step sequencing: log enables per cycle -> order is ARK, then (SB,SR,MC,ARK)x9, then SB,SR,ARK; mc_enable high exactly 9 times and never in round 10; key_index is 0..10 at successive ARK steps.
- MixColumns capture: force mc_out column=04 66 81 E5 while mc_enable=1 in round 1 -> state_q[127:96]=32'h046681E5 on the next cycle.
- Key stall and ignored start: key_valid=0 for 3 cycles in round-4 ARK, and pulse start during SR -> done at edge 43; ciphertext unchanged from the no-stall run; the extra start has no effect.
- Abort (with AES_CTRL_ABORT_EN): abort=1 during round-6 MC -> IDLE next cycle, busy=0, state_q=0, no done; the next start is accepted.
